// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator: format selects, occupancy states, legal XLENs.
// Types and helpers only; no logic of its own.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_Z,
        IMM_SH,
        IMM_RSVD
    } imm_sel_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decode: (instr, sel) -> XLEN immediate plus reserved-select flag.
// Zero latency; no handshake, the caller registers the result.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_sel_e        sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Opcode bits never feed any immediate field.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (sel)
            IMM_I:  imm = XLEN'($signed(instr[31:20]));
            IMM_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            IMM_Z:  imm = XLEN'(instr[19:15]);
            IMM_SH: begin
                if (XLEN == XLEN_64) begin
                    imm = XLEN'(instr[25:20]);
                end else begin
                    imm = XLEN'(instr[24:20]);
                end
            end
            IMM_RSVD: illegal = 1'b1;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with two-entry skid buffer; output valid one cycle after accept.
// in_ready is a function of occupancy only, so one extra entry is absorbed after out_ready drops.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (in_instr),
        .sel     (imm_sel_e'(in_sel)),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    occ_e             state_q, state_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_ill_q, main_ill_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;

    logic in_xfer;
    logic out_xfer;

    assign in_ready    = (state_q != OCC_TWO) && !rst;
    assign out_valid   = (state_q != OCC_EMPTY) && !rst;
    assign out_imm     = main_imm_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;

        // Flush discards everything, including this cycle's handshakes.
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        state_d    = OCC_ONE;
                        main_imm_d = dec_imm;
                        main_tag_d = in_tag;
                        main_ill_d = dec_illegal;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d    = OCC_TWO;
                        skid_imm_d = dec_imm;
                        skid_tag_d = in_tag;
                        skid_ill_d = dec_illegal;
                    end else if (out_xfer && !in_xfer) begin
                        state_d = OCC_EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        main_imm_d = dec_imm;
                        main_tag_d = in_tag;
                        main_ill_d = dec_illegal;
                    end
                end
                OCC_TWO: begin
                    if (out_xfer) begin
                        state_d    = OCC_ONE;
                        main_imm_d = skid_imm_q;
                        main_tag_d = skid_tag_q;
                        main_ill_d = skid_ill_q;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_ill_q <= main_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against a queue-based reference model with arithmetic immediate decoding.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [4:0]  in_tag;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [4:0]  tag;
        logic        ill;
    } ent_t;

    ent_t model_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
    );

    // Immediate value as a signed integer, from the format field layouts.
    function automatic longint ref_imm(input logic [31:0] w, input logic [2:0] s, input int xlen);
        longint v;
        v = 0;
        case (s)
            3'd0: begin v = longint'(w[31:20]); if (v >= 2048) v -= 4096; end
            3'd1: begin v = longint'({w[31:25], w[11:7]}); if (v >= 2048) v -= 4096; end
            3'd2: begin v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (v >= 4096) v -= 8192; end
            3'd3: begin
                v = longint'(w[31:12]) * 4096;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
            end
            3'd4: begin
                v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0});
                if (v >= 1048576) v -= 2097152;
            end
            3'd5: v = longint'(w[19:15]);
            3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic ent_t make_ent(input logic [31:0] w, input logic [2:0] s, input logic [4:0] t);
        ent_t   e;
        longint v32;
        v32     = ref_imm(w, s, 32);
        e.imm32 = v32[31:0];
        e.imm64 = ref_imm(w, s, 64);
        e.tag   = t;
        e.ill   = (s == 3'd7);
        return e;
    endfunction

    // Advance one clock, updating the model from the handshakes seen at that edge.
    task automatic tick();
        bit   in_x, out_x;
        ent_t e;
        in_x  = in_valid && !rst && (model_q.size() < 2);
        out_x = !rst && (model_q.size() > 0) && out_ready;
        e     = make_ent(in_instr, in_sel, in_tag);
        @(posedge clk);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (out_x) void'(model_q.pop_front());
            if (in_x) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({rdy32, rdy64} !== 2'b00) begin
            errors++; $display("FAIL reset_in_ready got %b required 00", {rdy32, rdy64});
        end
        checks++;
        if ({vld32, vld64, ill32, ill64} !== 4'b0000) begin
            errors++; $display("FAIL reset_valid_ill got %b required 0000", {vld32, vld64, ill32, ill64});
        end
        checks++;
        if ({imm32, imm64, tag32, tag64} !== '0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h required 0", imm32, imm64, tag32, tag64);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rdy32, rdy64} !== 2'b11) begin
            errors++; $display("FAIL release_in_ready got %b required 11", {rdy32, rdy64});
        end
    endtask

    task automatic test_formats();
        logic [31:0] v_instr [7] = '{32'hFFF00093, 32'hFE000EE3, 32'hFFFFF0EF, 32'h800000B7,
                                     32'h03F00013, 32'h000F8073, 32'h12345678};
        logic [2:0]  v_sel   [7] = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd6, 3'd5, 3'd7};
        logic [31:0] v_e32   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFE, 32'h80000000,
                                     32'd31, 32'd31, 32'd0};
        logic [63:0] v_e64   [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFE,
                                     64'hFFFFFFFF80000000, 64'd63, 64'd31, 64'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_instr = v_instr[i];
            in_sel   = v_sel[i];
            in_tag   = (i == 6) ? 5'd5 : 5'(i + 16);
            tick();
            in_valid = 1'b0;
            checks++;
            if ({vld32, vld64} !== 2'b11) begin
                errors++; $display("FAIL fmt%0d_valid got %b required 11", i, {vld32, vld64});
            end
            checks++;
            if (imm32 !== v_e32[i] || imm64 !== v_e64[i]) begin
                errors++; $display("FAIL fmt%0d_imm got %h %h required %h %h", i, imm32, imm64, v_e32[i], v_e64[i]);
            end
            checks++;
            if (tag32 !== in_tag || tag64 !== in_tag || ill32 !== (i == 6) || ill64 !== (i == 6)) begin
                errors++; $display("FAIL fmt%0d_tag_ill got %0d %0d %b %b required %0d %b",
                                   i, tag32, tag64, ill32, ill64, in_tag, (i == 6));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          next_tag;
        int          got[$];
        bit          prev_stall;
        logic [95:0] prev_dat;
        next_tag   = 1;
        prev_stall = 1'b0;
        prev_dat   = '0;
        for (int c = 1; c <= 40 && got.size() < 6; c++) begin
            in_valid  = (next_tag <= 6);
            in_tag    = 5'(next_tag);
            in_instr  = $urandom;
            in_sel    = 3'($urandom_range(0, 6));
            out_ready = !(c >= 3 && c <= 6);
            checks++;
            if (rdy32 !== (model_q.size() < 2) || rdy64 !== (model_q.size() < 2)) begin
                errors++; $display("FAIL bp_in_ready c%0d got %b %b required %b", c, rdy32, rdy64, model_q.size() < 2);
            end
            checks++;
            if (vld32 !== (model_q.size() > 0) || vld64 !== (model_q.size() > 0)) begin
                errors++; $display("FAIL bp_valid c%0d got %b %b required %b", c, vld32, vld64, model_q.size() > 0);
            end
            if (prev_stall) begin
                checks++;
                if ({imm32, imm64} !== prev_dat) begin
                    errors++; $display("FAIL bp_hold c%0d got %h required %h", c, {imm32, imm64}, prev_dat);
                end
            end
            if (model_q.size() > 0) begin
                checks++;
                if (tag32 !== model_q[0].tag || imm32 !== model_q[0].imm32 || imm64 !== model_q[0].imm64) begin
                    errors++; $display("FAIL bp_data c%0d got %0d %h %h required %0d %h %h", c, tag32, imm32, imm64,
                                       model_q[0].tag, model_q[0].imm32, model_q[0].imm64);
                end
                if (out_ready) got.push_back(int'(tag32));
            end
            prev_stall = (model_q.size() > 0) && !out_ready;
            prev_dat   = {imm32, imm64};
            if (in_valid && model_q.size() < 2) next_tag++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL bp_count got %0d required 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++;
            if (got[i] != i + 1) begin
                errors++; $display("FAIL bp_order idx%0d got %0d required %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_instr  = $urandom;
        in_tag    = 5'd10;
        tick();
        in_tag    = 5'd11;
        tick();
        checks++;
        if ({rdy32, rdy64} !== 2'b00) begin
            errors++; $display("FAIL flush_full_ready got %b required 00", {rdy32, rdy64});
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_tag    = 5'd12;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
            errors++; $display("FAIL flush_next got %b required 0011", {vld32, vld64, rdy32, rdy64});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({vld32, vld64} !== 2'b00) begin
                errors++; $display("FAIL flush_leak%0d got tag %0d", i, tag32);
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd7;
        in_tag    = 5'd20;
        tick();
        in_tag    = 5'd21;
        tick();
        in_valid  = 1'b0;
        rst       = 1'b1;
        #1;
        checks++;
        if ({rdy32, rdy64} !== 2'b00) begin
            errors++; $display("FAIL mrst_in_ready got %b required 00", {rdy32, rdy64});
        end
        tick();
        checks++;
        if ({vld32, vld64, ill32, ill64} !== 4'b0000 || {imm32, imm64, tag32, tag64} !== '0) begin
            errors++; $display("FAIL mrst_outputs got %b %h %h %0d", {vld32, vld64, ill32, ill64}, imm32, imm64, tag32);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rdy32, rdy64} !== 2'b11) begin
            errors++; $display("FAIL mrst_release_ready got %b required 11", {rdy32, rdy64});
        end
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_instr = $urandom;
        in_tag   = 5'd22;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({vld32, vld64} !== 2'b11 || tag32 !== 5'd22 || imm32 !== model_q[0].imm32 || imm64 !== model_q[0].imm64) begin
            errors++; $display("FAIL mrst_single got %b %0d %h %h", {vld32, vld64}, tag32, imm32, imm64);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_instr  = $urandom;
            in_sel    = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom);
            checks++;
            if (rdy32 !== (model_q.size() < 2) || rdy64 !== (model_q.size() < 2) ||
                vld32 !== (model_q.size() > 0) || vld64 !== (model_q.size() > 0)) begin
                errors++; $display("FAIL rnd_hs c%0d got %b%b%b%b occupancy %0d", c, rdy32, rdy64, vld32, vld64, model_q.size());
            end
            if (model_q.size() > 0) begin
                checks++;
                if (imm32 !== model_q[0].imm32 || imm64 !== model_q[0].imm64 || tag32 !== model_q[0].tag ||
                    tag64 !== model_q[0].tag || ill32 !== model_q[0].ill || ill64 !== model_q[0].ill) begin
                    errors++; $display("FAIL rnd_data c%0d got %h %h %0d %b required %h %h %0d %b", c, imm32, imm64,
                                       tag32, ill32, model_q[0].imm32, model_q[0].imm64, model_q[0].tag, model_q[0].ill);
                end
            end
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_sel    = '0;
        in_tag    = '0;
        @(negedge clk);
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction word per cycle over a valid/ready handshake and decodes the immediate for all RV32/RV64 base formats plus CSR zimm and shift-amount forms. The result is presented as a sign- or zero-extended XLEN value, one cycle later. A two-entry skid buffer gives full throughput under back-pressure, and a synchronous flush supports branch redirect. Sits between the instruction fetch register and the decode/execute boundary, replacing the combinational generator.

## Interface

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried unchanged alongside the immediate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drops all buffered entries and any input offered in the same cycle.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input this cycle.
- in_instr  in  32  instruction word.
- in_sel  in  3  immediate format select (imm_sel_e).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  XLEN  decoded immediate.
- out_tag  out  TAG_W  tag of the presented entry.
- out_illegal  out  1  in_sel was the reserved encoding.

## Operation

- Decode, with sext/zext to XLEN:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25],instr[11:7]}).
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - 011 U: sext({instr[31:12],12'b0}). For XLEN=64 this sign-extends from bit 31.
  - 100 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - 101 Z: zext(instr[19:15]) (CSR zimm).
  - 110 SH: zext(instr[25:20]) if XLEN=64, else zext(instr[24:20]).
  - 111: imm = 0 and out_illegal = 1. The entry is still passed through, never dropped.
- An input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Storage: a main register drives the outputs; a skid register holds an overflow entry.
- Occupancy FSM: EMPTY, ONE, TWO.
  - EMPTY: input transfer -> ONE.
  - ONE:
    - input transfer without output transfer -> TWO; the new entry goes to skid.
    - output transfer without input transfer -> EMPTY.
    - both -> ONE; the new entry goes to main.
  - TWO: in_ready = 0. Output transfer -> ONE; skid moves to main.
- in_ready = (state != TWO) && !rst. It is a registered function of state and does not depend combinationally on out_ready.
- Entries leave in strict input order.
- flush: next state EMPTY regardless of the handshakes that cycle. Any input transfer in that cycle is discarded; out_ready that cycle is ignored.
- Reset outputs: out_valid = 0, out_imm = 0, out_tag = 0, out_illegal = 0, in_ready = 0 while rst is high. State is EMPTY.
- rst takes priority over flush. Reset mid-stream discards all entries.
- Data registers change only on load. out_imm, out_tag and out_illegal stay stable while out_valid && !out_ready.

## Timing

- Latency: an input accepted in cycle N has out_valid = 1 in cycle N+1.
- Throughput: 1 entry/cycle while out_ready is held high.
- Back-pressure: if out_ready drops, one further input is still absorbed (into skid), then in_ready falls the next cycle.
- After rst is released, in_ready = 1 on the first cycle.
- After flush, out_valid = 0 and in_ready = 1 on the next cycle.

## Structure

- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_sel_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_RSVD};
  - localparam for the legal XLEN values.
- Sub-module imm_decode: purely combinational, parametrised by XLEN, maps (instr, sel) to (imm, illegal).
- The top level holds the skid buffer and occupancy FSM.
- An elaboration-time assertion rejects XLEN other than 32 or 64.

## Test plan

- Format decode, XLEN=32, out_ready = 1:
  - I: in_instr = 0xFFF00093, sel I -> out_imm = 0xFFFFFFFF one cycle later.
  - B: in_instr = 0xFE000EE3, sel B -> out_imm = 0xFFFFFFFC.
  - J: in_instr = 0xFFFFF0EF, sel J -> out_imm = 0xFFFFFFFE.
- XLEN=64:
  - U: in_instr = 0x800000B7, sel U -> out_imm = 0xFFFFFFFF80000000.
  - SH: in_instr with instr[25:20] = 6'h3F, sel SH -> out_imm = 63.
  - Z: in_instr with instr[19:15] = 5'h1F, sel Z -> out_imm = 31 (zero-extended).
- Reserved select: sel = 111 with tag 5 -> out_imm = 0, out_illegal = 1, out_tag = 5; the entry is delivered.
- Back-pressure:
  - Stream tags 1..6 back-to-back; hold out_ready low for cycles 3-6.
  - in_ready drops one cycle after the skid fills.
  - The output holds its value while stalled.
  - Tags emerge 1..6 in order with none lost or duplicated.
- Flush:
  - With state TWO, assert flush together with in_valid.
  - Next cycle: out_valid = 0, in_ready = 1, and the flushed tags never appear.
- Reset:
  - Assert rst with two entries buffered.
  - During rst: in_ready = 0.
  - Next cycle: out_valid = 0, out_imm = 0, out_tag = 0, out_illegal = 0.
  - After release: a single input appears one cycle after acceptance.
